// File: rtl/sobel_stream_if.sv
// Stream bundle for sobel_stream_core: window/config in, edge pixel/direction out.
// Handshake: a beat moves when valid and ready are both high on a rising clock edge.
// The sender keeps valid and payload stable until that edge.
interface sobel_stream_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_0_i, data_1_i, data_2_i;
  logic [DATA_W-1:0] data_3_i, data_4_i, data_5_i;
  logic [DATA_W-1:0] data_6_i, data_7_i, data_8_i;
  logic              valid_i;
  logic              ready_o;
  logic [1:0]        mode_i;
  logic [DATA_W-1:0] thresh_i;
  logic              valid_o;
  logic              ready_i;
  logic [DATA_W-1:0] grey_o;
  logic [1:0]        dir_o;

  modport master (
    output data_0_i, data_1_i, data_2_i, data_3_i, data_4_i,
    output data_5_i, data_6_i, data_7_i, data_8_i,
    output valid_i, mode_i, thresh_i, ready_i,
    input  ready_o, valid_o, grey_o, dir_o
  );

  modport slave (
    input  data_0_i, data_1_i, data_2_i, data_3_i, data_4_i,
    input  data_5_i, data_6_i, data_7_i, data_8_i,
    input  valid_i, mode_i, thresh_i, ready_i,
    output ready_o, valid_o, grey_o, dir_o
  );
endinterface

// File: rtl/sobel_stream_core.sv
// Four-stage Sobel gradient/threshold pipeline with global stall and a saturating edge counter.
// Define SOBEL_DIR_EN to compute the quantised gradient direction on dir_o.
module sobel_stream_core #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] edge_cnt_o,
  sobel_stream_if.slave    bus
);
  localparam int GW = DATA_W + 2;
  localparam int MW = DATA_W + 3;

  logic              en;
  logic [3:0]        vld_q, vld_d;
  logic [GW-1:0]     gpx_q, gpx_d, gnx_q, gnx_d, gpy_q, gpy_d, gny_q, gny_d;
  logic [1:0]        mode1_q, mode1_d, mode2_q, mode2_d;
  logic [DATA_W-1:0] thr1_q, thr1_d, thr2_q, thr2_d, thr3_q, thr3_d;
  logic [GW-1:0]     gdx_q, gdx_d, gdy_q, gdy_d;
  logic [MW-1:0]     m_q, m_d;
  logic [DATA_W-1:0] grey_q, grey_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_base;
`ifdef SOBEL_DIR_EN
  logic              sx_q, sx_d, sy_q, sy_d;
  logic [1:0]        dir3_q, dir3_d, dir_q, dir_d;
`endif

  // The whole pipe advances together; a held output freezes every stage.
  assign en          = bus.ready_i | ~vld_q[3];
  assign bus.ready_o = en;
  assign bus.valid_o = vld_q[3];
  assign bus.grey_o  = grey_q;
  assign edge_cnt_o  = cnt_q;
`ifdef SOBEL_DIR_EN
  assign bus.dir_o   = dir_q;
`else
  assign bus.dir_o   = 2'b00;
`endif

  always_comb begin
    vld_d   = vld_q;
    gpx_d   = gpx_q;
    gnx_d   = gnx_q;
    gpy_d   = gpy_q;
    gny_d   = gny_q;
    mode1_d = mode1_q;
    thr1_d  = thr1_q;
    gdx_d   = gdx_q;
    gdy_d   = gdy_q;
    mode2_d = mode2_q;
    thr2_d  = thr2_q;
    m_d     = m_q;
    thr3_d  = thr3_q;
    grey_d  = grey_q;
`ifdef SOBEL_DIR_EN
    sx_d    = sx_q;
    sy_d    = sy_q;
    dir3_d  = dir3_q;
    dir_d   = dir_q;
`endif
    if (en) begin
      vld_d   = {vld_q[2:0], bus.valid_i};
      gpx_d   = {2'b00, bus.data_0_i} + {1'b0, bus.data_3_i, 1'b0} + {2'b00, bus.data_6_i};
      gnx_d   = {2'b00, bus.data_2_i} + {1'b0, bus.data_5_i, 1'b0} + {2'b00, bus.data_8_i};
      gpy_d   = {2'b00, bus.data_0_i} + {1'b0, bus.data_1_i, 1'b0} + {2'b00, bus.data_2_i};
      gny_d   = {2'b00, bus.data_6_i} + {1'b0, bus.data_7_i, 1'b0} + {2'b00, bus.data_8_i};
      mode1_d = bus.mode_i;
      thr1_d  = bus.thresh_i;

      gdx_d   = (gpx_q >= gnx_q) ? (gpx_q - gnx_q) : (gnx_q - gpx_q);
      gdy_d   = (gpy_q >= gny_q) ? (gpy_q - gny_q) : (gny_q - gpy_q);
      mode2_d = mode1_q;
      thr2_d  = thr1_q;
`ifdef SOBEL_DIR_EN
      sx_d    = (gpx_q >= gnx_q);
      sy_d    = (gpy_q >= gny_q);
`endif

      case (mode2_q)
        2'b00:   m_d = {1'b0, gdx_q} + {1'b0, gdy_q};
        2'b01:   m_d = (gdx_q >= gdy_q) ? {1'b0, gdx_q} : {1'b0, gdy_q};
        2'b10:   m_d = {1'b0, gdx_q};
        default: m_d = {1'b0, gdy_q};
      endcase
      thr3_d  = thr2_q;
`ifdef SOBEL_DIR_EN
      if ({1'b0, gdx_q} >= {gdy_q, 1'b0})      dir3_d = 2'b00;
      else if ({1'b0, gdy_q} >= {gdx_q, 1'b0}) dir3_d = 2'b01;
      else if (sx_q == sy_q)                   dir3_d = 2'b10;
      else                                     dir3_d = 2'b11;
      dir_d   = dir3_q;
`endif

      // m at or below the threshold fits in DATA_W bits, so the slice is exact.
      grey_d  = (m_q > {3'b000, thr3_q}) ? {DATA_W{1'b1}} : m_q[DATA_W-1:0];
    end

    cnt_base = clr_i ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (vld_q[3] && bus.ready_i && (grey_q == {DATA_W{1'b1}}) && (cnt_base != {CNT_W{1'b1}}))
      cnt_d = cnt_base + 1'b1;
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      vld_q   <= '0;
      gpx_q   <= '0;
      gnx_q   <= '0;
      gpy_q   <= '0;
      gny_q   <= '0;
      mode1_q <= '0;
      thr1_q  <= '0;
      gdx_q   <= '0;
      gdy_q   <= '0;
      mode2_q <= '0;
      thr2_q  <= '0;
      m_q     <= '0;
      thr3_q  <= '0;
      grey_q  <= '0;
      cnt_q   <= '0;
`ifdef SOBEL_DIR_EN
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
      dir3_q  <= '0;
      dir_q   <= '0;
`endif
    end else begin
      vld_q   <= vld_d;
      gpx_q   <= gpx_d;
      gnx_q   <= gnx_d;
      gpy_q   <= gpy_d;
      gny_q   <= gny_d;
      mode1_q <= mode1_d;
      thr1_q  <= thr1_d;
      gdx_q   <= gdx_d;
      gdy_q   <= gdy_d;
      mode2_q <= mode2_d;
      thr2_q  <= thr2_d;
      m_q     <= m_d;
      thr3_q  <= thr3_d;
      grey_q  <= grey_d;
      cnt_q   <= cnt_d;
`ifdef SOBEL_DIR_EN
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      dir3_q  <= dir3_d;
      dir_q   <= dir_d;
`endif
    end
  end
endmodule

// File: tb/tb_sobel_stream_core.sv
// Directed bench for sobel_stream_core (DATA_W=8, CNT_W=2); expected values worked out by hand.
module tb_sobel_stream_core;
  logic       sys_clk;
  logic       sys_rst;
  logic       clr;
  logic [1:0] edge_cnt;
  int         checks;
  int         failures;
  int         exp_cnt;
  logic [7:0] exp_q[$];

  sobel_stream_if #(.DATA_W(8)) bus ();

  sobel_stream_core #(.DATA_W(8), .CNT_W(2)) dut (
    .sys_clk_i (sys_clk),
    .sys_rst_i (sys_rst),
    .clr_i     (clr),
    .edge_cnt_o(edge_cnt),
    .bus       (bus)
  );

  // Clock and watchdog
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] win(input int a0, input int a1, input int a2,
                                      input int a3, input int a4, input int a5,
                                      input int a6, input int a7, input int a8);
    logic [71:0] w;
    w = {a8[7:0], a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    return w;
  endfunction

  // Driver tasks
  task automatic drive_window(input logic [71:0] w, input logic [1:0] mode, input logic [7:0] thr);
    bus.data_0_i = w[7:0];
    bus.data_1_i = w[15:8];
    bus.data_2_i = w[23:16];
    bus.data_3_i = w[31:24];
    bus.data_4_i = w[39:32];
    bus.data_5_i = w[47:40];
    bus.data_6_i = w[55:48];
    bus.data_7_i = w[63:56];
    bus.data_8_i = w[71:64];
    bus.mode_i   = mode;
    bus.thresh_i = thr;
    bus.valid_i  = 1'b1;
  endtask

  function automatic int cnt_step(input int cnt, input bit clr_now, input bit is_edge);
    int c;
    c = clr_now ? 0 : cnt;
    if (is_edge && c < 3) c = c + 1;
    return c;
  endfunction

  // One isolated window through an empty pipe, checking exact 4-cycle latency.
  task automatic run_one(input string tag, input logic [71:0] w, input logic [1:0] mode,
                         input logic [7:0] thr, input logic [7:0] exp_grey,
                         input logic [1:0] dir_en_val, input bit clr_at_out);
    logic [1:0] exp_dir;
`ifdef SOBEL_DIR_EN
    exp_dir = dir_en_val;
`else
    exp_dir = 2'b00;
`endif
    @(negedge sys_clk);
    bus.ready_i = 1'b1;
    drive_window(w, mode, thr);
    #1 check({tag, "_ready"}, bus.ready_o, 1'b1);
    @(negedge sys_clk);
    bus.valid_i = 1'b0;
    check({tag, "_lat1"}, bus.valid_o, 1'b0);
    repeat (2) begin
      @(negedge sys_clk);
      check({tag, "_lat23"}, bus.valid_o, 1'b0);
    end
    @(negedge sys_clk);
    check({tag, "_valid"}, bus.valid_o, 1'b1);
    check({tag, "_grey"}, bus.grey_o, exp_grey);
    check({tag, "_dir"}, bus.dir_o, exp_dir);
    clr = clr_at_out;
    exp_cnt = cnt_step(exp_cnt, clr_at_out, exp_grey == 8'hFF);
    @(negedge sys_clk);
    clr = 1'b0;
    check({tag, "_cnt"}, edge_cnt, exp_cnt[1:0]);
    check({tag, "_drain"}, bus.valid_o, 1'b0);
  endtask

  // Scoreboard-driven stream with a 5-cycle downstream hold in the middle.
  task automatic stream_backpressure();
    int sent;
    int got;
    bit hold;
    bit in_xfer;
    bit out_xfer;
    sent = 0;
    got  = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge sys_clk);
      hold = (c >= 6 && c <= 10);
      bus.ready_i = !hold;
      if (sent < 8) drive_window(win(10 * (sent + 1), 0, 0, 0, 0, 0, 0, 0, 0), 2'b00, 8'd175);
      else          bus.valid_i = 1'b0;
      #1;
      in_xfer  = bus.valid_i && bus.ready_o;
      out_xfer = bus.valid_o && bus.ready_i;
      if (hold) begin
        check("bp_hold_ready", bus.ready_o, 1'b0);
        check("bp_hold_valid", bus.valid_o, 1'b1);
        if (exp_q.size() > 0) check("bp_hold_grey", bus.grey_o, exp_q[0]);
        else                  check("bp_hold_queue", 0, 1);
      end
      if (out_xfer) begin
        if (exp_q.size() > 0) check("bp_out_grey", bus.grey_o, exp_q.pop_front());
        else                  check("bp_out_extra", 1, 0);
        got++;
      end
      if (in_xfer) begin
        exp_q.push_back(8'(20 * (sent + 1)));
        sent++;
      end
    end
    check("bp_sent", sent, 8);
    check("bp_got", got, 8);
    check("bp_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_cnt  = 0;
    sys_rst  = 1'b1;
    clr      = 1'b0;
    bus.ready_i = 1'b1;
    drive_window(win(0, 0, 0, 0, 0, 0, 0, 0, 0), 2'b00, 8'd0);
    bus.valid_i = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("rst_valid", bus.valid_o, 1'b0);
    check("rst_grey", bus.grey_o, 8'd0);
    check("rst_dir", bus.dir_o, 2'b00);
    check("rst_cnt", edge_cnt, 2'd0);
    check("rst_ready", bus.ready_o, 1'b1);

    run_one("d0_m00", win(10, 0, 0, 0, 0, 0, 0, 0, 0), 2'b00, 8'd175, 8'd20, 2'b10, 1'b0);
    run_one("d0_m01", win(10, 0, 0, 0, 0, 0, 0, 0, 0), 2'b01, 8'd175, 8'd10, 2'b10, 1'b0);
    run_one("col_m00", win(255, 0, 0, 255, 0, 0, 255, 0, 0), 2'b00, 8'd175, 8'd255, 2'b00, 1'b0);
    run_one("col_m11", win(255, 0, 0, 255, 0, 0, 255, 0, 0), 2'b11, 8'd175, 8'd0, 2'b00, 1'b0);
    for (int md = 0; md < 4; md++)
      run_one("flat", win(100, 100, 100, 100, 100, 100, 100, 100, 100), 2'(md), 8'd175, 8'd0, 2'b00, 1'b0);
    run_one("thr_eq", win(175, 0, 0, 0, 0, 0, 0, 0, 0), 2'b10, 8'd175, 8'd175, 2'b10, 1'b0);
    run_one("thr_gt", win(176, 0, 0, 0, 0, 0, 0, 0, 0), 2'b10, 8'd175, 8'd255, 2'b10, 1'b0);
    run_one("thr_sum", win(88, 0, 0, 0, 0, 0, 0, 0, 0), 2'b00, 8'd175, 8'd255, 2'b10, 1'b0);
    run_one("dir_vert", win(0, 30, 0, 0, 0, 0, 0, 0, 0), 2'b00, 8'd175, 8'd60, 2'b01, 1'b0);
    run_one("dir_anti", win(0, 0, 10, 0, 0, 0, 0, 0, 0), 2'b00, 8'd175, 8'd20, 2'b11, 1'b0);

    stream_backpressure();

    @(negedge sys_clk);
    bus.ready_i = 1'b1;
    clr = 1'b1;
    exp_cnt = 0;
    @(negedge sys_clk);
    clr = 1'b0;
    check("clr_alone", edge_cnt, 2'd0);

    for (int k = 0; k < 5; k++)
      run_one("sat", win(255, 0, 0, 255, 0, 0, 255, 0, 0), 2'b00, 8'd175, 8'd255, 2'b00, 1'b0);
    run_one("clr_inc", win(255, 0, 0, 255, 0, 0, 255, 0, 0), 2'b00, 8'd175, 8'd255, 2'b00, 1'b1);

    // Reset with three windows in flight
    for (int k = 0; k < 3; k++) begin
      @(negedge sys_clk);
      drive_window(win(255, 0, 0, 255, 0, 0, 255, 0, 0), 2'b00, 8'd175);
    end
    @(negedge sys_clk);
    bus.valid_i = 1'b0;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    check("midrst_valid", bus.valid_o, 1'b0);
    check("midrst_cnt", edge_cnt, 2'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge sys_clk);
      check("midrst_no_stale", bus.valid_o, 1'b0);
    end
    check("midrst_cnt_after", edge_cnt, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
